atm_txn_initiator: RTL

Transaction initiator that drives the ATM core's request inputs on behalf of a host and returns the core's result. It accepts one request at a time over a valid/ready channel and registers the request onto the ATM core's operation, account, PIN, new-PIN, amount and language inputs. It then waits for the core to reach its completion state and hands back success, balance and a timeout flag over a second valid/ready channel. It sits between the host/test sequencer and the ATM core, so the core is always driven with stable, fully-latched requests.

---
 rtl/atm_txn_initiator_if.sv | 43 ++++
 rtl/atm_txn_initiator.sv | 130 +++++++++++++
 2 files changed

// File: rtl/atm_txn_initiator_if.sv
// Host request/response channels and ATM core request/result bus for atm_txn_initiator.
// slave = initiator view, master = host/core view.
interface atm_txn_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [3:0]  req_acc;
    logic [15:0] req_pin;
    logic [15:0] req_newpin;
    logic [31:0] req_amount;
    logic        req_lang;

    logic [2:0]  atm_operation;
    logic [3:0]  atm_acc_num;
    logic [15:0] atm_pin;
    logic [15:0] atm_new_pin;
    logic [31:0] atm_amount;
    logic        atm_language;
    logic [31:0] atm_balance;
    logic        atm_success;
    logic [2:0]  atm_state;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_success;
    logic [31:0] rsp_balance;
    logic        rsp_timeout;
    logic [15:0] txn_count;

    modport slave (
        input  req_valid, req_op, req_acc, req_pin, req_newpin, req_amount, req_lang,
        input  atm_balance, atm_success, atm_state, rsp_ready,
        output req_ready, atm_operation, atm_acc_num, atm_pin, atm_new_pin, atm_amount,
        output atm_language, rsp_valid, rsp_success, rsp_balance, rsp_timeout, txn_count
    );

    modport master (
        output req_valid, req_op, req_acc, req_pin, req_newpin, req_amount, req_lang,
        output atm_balance, atm_success, atm_state, rsp_ready,
        input  req_ready, atm_operation, atm_acc_num, atm_pin, atm_new_pin, atm_amount,
        input  atm_language, rsp_valid, rsp_success, rsp_balance, rsp_timeout, txn_count
    );
endinterface

// File: rtl/atm_txn_initiator.sv
// Latches one host request onto the ATM core inputs, waits for the core's done state, returns the result.
// Define ATM_INIT_TIMEOUT_EN to compile in the WAIT timeout path.
module atm_txn_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [2:0]  DONE_STATE     = 3'd3,
    parameter logic [2:0]  IDLE_OP        = 3'd0,
    parameter int unsigned MIN_WAIT       = 1
) (
    input logic clk,
    input logic rst,
    atm_txn_initiator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q;
    logic        accept, done;
    logic [2:0]  op_q;
    logic [3:0]  acc_q;
    logic [15:0] pin_q, newpin_q;
    logic [31:0] amount_q;
    logic        lang_q;
    logic        rsp_success_q;
    logic [31:0] rsp_balance_q;
    logic [15:0] txn_cnt_q;
`ifdef ATM_INIT_TIMEOUT_EN
    logic        tmo;
    logic        rsp_timeout_q;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
`ifdef ATM_INIT_TIMEOUT_EN
        tmo     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && !rst) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // MIN_WAIT masks a DONE_STATE left over from the previous transaction
                if (wait_cnt_q >= 8'(MIN_WAIT) && bus.atm_state == DONE_STATE) begin
                    done    = 1'b1;
                    state_d = RESP;
                end
`ifdef ATM_INIT_TIMEOUT_EN
                else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    tmo     = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            op_q          <= IDLE_OP;
            acc_q         <= '0;
            pin_q         <= '0;
            newpin_q      <= '0;
            amount_q      <= '0;
            lang_q        <= 1'b0;
            rsp_success_q <= 1'b0;
            rsp_balance_q <= '0;
            txn_cnt_q     <= '0;
`ifdef ATM_INIT_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= bus.req_op;
                acc_q      <= bus.req_acc;
                pin_q      <= bus.req_pin;
                newpin_q   <= bus.req_newpin;
                amount_q   <= bus.req_amount;
                lang_q     <= bus.req_lang;
                wait_cnt_q <= '0;
            end else if (state_q == WAIT && wait_cnt_q != '1) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            if (done) begin
                rsp_success_q <= bus.atm_success;
                rsp_balance_q <= bus.atm_balance;
                txn_cnt_q     <= txn_cnt_q + 16'd1;
                op_q          <= IDLE_OP;
`ifdef ATM_INIT_TIMEOUT_EN
                rsp_timeout_q <= 1'b0;
`endif
            end
`ifdef ATM_INIT_TIMEOUT_EN
            if (tmo) begin
                rsp_success_q <= 1'b0;
                rsp_balance_q <= '0;
                rsp_timeout_q <= 1'b1;
                op_q          <= IDLE_OP;
            end
`endif
        end
    end

    assign bus.req_ready     = (state_q == IDLE) && !rst;
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.atm_operation = op_q;
    assign bus.atm_acc_num   = acc_q;
    assign bus.atm_pin       = pin_q;
    assign bus.atm_new_pin   = newpin_q;
    assign bus.atm_amount    = amount_q;
    assign bus.atm_language  = lang_q;
    assign bus.rsp_success   = rsp_success_q;
    assign bus.rsp_balance   = rsp_balance_q;
    assign bus.txn_count     = txn_cnt_q;
`ifdef ATM_INIT_TIMEOUT_EN
    assign bus.rsp_timeout   = rsp_timeout_q;
`else
    assign bus.rsp_timeout   = 1'b0;
`endif
endmodule
